agc_timepulse_gen: RTL and testbench
====================================

Name: agc_timepulse_gen

Overview:
- Parametrised successor to the fixed 12-pulse AGC timer: generates the memory-cycle time-pulse ring (T01..Tn), the intra-pulse phase strobes (PHS2/PHS4, RT/WT/CT), the EVNSET/ODDSET_ stage strobes and a memory-cycle-time (MCT) count.
- Adds a power-on/restart GOJAM sequencer and a monitor stop/single-step controller (MSTP/MSTRTP).
- Sits at the root of the timing tree and feeds control-pulse and memory-timing logic.

Parameters:
- NUM_T, 12, time pulses per MCT (≥4).
- PHASES, 4, clock cycles per time pulse (≥4, even).
- RT_PH, 0, phase index asserting RT.
- WT_PH, 2, phase index asserting WT.
- CT_PH, 3, phase index asserting CT.
- GOJAM_CYC, 8, clock cycles GOJAM is held after the last trigger (≥1).
- CNT_W, 16, MCT counter width.

Ports:
- CLOCK  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- STRT1  in  1  restart request (synchronous level).
- STRT2  in  1  restart request (synchronous level).
- MSTP  in  1  monitor stop request (level).
- MSTRTP  in  1  monitor single-step (level; rising edge acts).
- T  out  NUM_T  one-hot time pulses, bit0 = T01.
- T_  out  NUM_T  bitwise inverse of T.
- PHS2  out  1  high when phase == 1.
- PHS4  out  1  high when phase == 3.
- RT, WT, CT  out  1 each  phase strobes at RT_PH/WT_PH/CT_PH.
- EVNSET  out  1  last phase of every odd-numbered pulse (T01, T03, ...).
- ODDSET_  out  1  active-low; last phase of every even-numbered pulse.
- GOJAM  out  1  restart in progress.
- GOJAM_  out  1  inverse of GOJAM.
- STOP  out  1  ring halted by monitor.
- MCT  out  CNT_W  count of completed MCTs.
- MT  out  NUM_T  monitor copy of T (optional feature).
- TERR  out  1  ring-integrity error (optional feature).

Behaviour:
- State: ph (0..PHASES-1), tp (0..NUM_T-1), idle flag, jam counter, stop FSM, mct.
- Reset (rst low, async): ph=0, tp=0, idle=1, jam=GOJAM_CYC, FSM=RUN, mct=0.
  - Outputs during reset: GOJAM=1, GOJAM_=0, T=0, T_=all 1, all strobes 0, ODDSET_=1, STOP=0, MT=0, TERR=0.
- All outputs decode from registered state; no input→output combinational path.
- GOJAM:
  - GOJAM = (jam != 0).
  - If STRT1 or STRT2 is high at an edge: jam←GOJAM_CYC, ph←0, tp←0, idle←1, FSM←RUN. This aborts any MCT mid-pulse and overrides stop/step.
  - Otherwise, while jam != 0: jam decrements by 1.
  - On the edge where jam goes 1→0: idle←0. The first cycle with GOJAM=0 shows T01=1, ph=0.
- Run (idle=0, FSM allows advance):
  - ph increments each cycle.
  - At ph==PHASES-1: ph←0 and tp advances.
  - At tp==NUM_T-1 and ph==PHASES-1 (end of MCT): tp←0 and mct←mct+1, wrapping modulo 2^CNT_W.
- Decode (all strobes gated by !idle):
  - T[i] = !idle && tp==i.
  - PHS2, PHS4, RT, WT, CT per phase index.
- Stop FSM, states RUN, HALT, STEP:
  - RUN→HALT: MSTP high at the end-of-MCT edge. Then idle←1, ph=0, tp=0, STOP=1, T=0.
  - MSTP sampled mid-MCT: the current MCT completes first.
  - HALT→RUN: MSTP low. The next cycle shows T01.
  - HALT→STEP: MSTRTP 0→1 edge while MSTP is high. Exactly one full MCT runs with STOP=0, then HALT again.
  - STEP→RUN: MSTP drops during STEP.
  - MSTRTP held high does not re-step; the edge detector needs a low sample before the next step.
  - MSTRTP edge and MSTP drop on the same cycle in HALT: go to RUN.
  - Restart has priority over every stop-FSM transition.

Optional Feature:
- Macro: AGC_TPG_MON_EN.
- Defined:
  - MT registers a copy of T, one cycle late.
  - TERR is a sticky flag, set if the registered T is ever not one-hot while idle=0, or is nonzero while idle=1. Cleared only by reset or GOJAM.
- Undefined: MT=0, TERR=0, no extra flops.

Test Plan:
- Reset release, no triggers → GOJAM=1 for exactly 8 cycles. Cycle 9 shows T=12'h001, ph=0, RT=1. T02 appears at cycle 13; T12→T01 wrap at cycle 57; MCT=1.
- STRT1 pulsed 1 cycle while T05 is active → GOJAM=1 from next cycle for 8 cycles; T=0 meanwhile; ring restarts at T01; MCT unchanged.
- EVNSET/ODDSET_ over one MCT → EVNSET high 6 times (last phase of T01, T03, ..., T11); ODDSET_ low 6 times (T02, ..., T12); never simultaneous.
- MSTP raised during T06 → T07..T12 complete; then STOP=1, T=0. MSTRTP edge → exactly 48 cycles of pulses, MCT+1, STOP=1 again. MSTP low → T01 next cycle.
- MCT set to 16'hFFFF, then one MCT runs → MCT=0.
- NUM_T=8, PHASES=6, AGC_TPG_MON_EN defined → MCT period 48 cycles; MT equals T delayed 1 cycle; TERR stays 0. Forcing tp state to two-hot sets TERR=1, and TERR holds until STRT2.

Source files
------------

// File: rtl/agc_timepulse_gen.sv
// rtl/agc_timepulse_gen.sv - AGC time-pulse ring, phase strobes, GOJAM restart and monitor stop/step; AGC_TPG_MON_EN adds MT/TERR ring monitor
module agc_timepulse_gen #(
    parameter int NUM_T     = 12,
    parameter int PHASES    = 4,
    parameter int RT_PH     = 0,
    parameter int WT_PH     = 2,
    parameter int CT_PH     = 3,
    parameter int GOJAM_CYC = 8,
    parameter int CNT_W     = 16
) (
    input  logic             CLOCK,
    input  logic             rst,
    input  logic             STRT1,
    input  logic             STRT2,
    input  logic             MSTP,
    input  logic             MSTRTP,
    output logic [NUM_T-1:0] T,
    output logic [NUM_T-1:0] T_,
    output logic             PHS2,
    output logic             PHS4,
    output logic             RT,
    output logic             WT,
    output logic             CT,
    output logic             EVNSET,
    output logic             ODDSET_,
    output logic             GOJAM,
    output logic             GOJAM_,
    output logic             STOP,
    output logic [CNT_W-1:0] MCT,
    output logic [NUM_T-1:0] MT,
    output logic             TERR
);

    localparam int PH_W  = $clog2(PHASES);
    localparam int JAM_W = $clog2(GOJAM_CYC + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PHASES - 1);
    localparam logic [PH_W-1:0]  PH_RT    = PH_W'(RT_PH);
    localparam logic [PH_W-1:0]  PH_WT    = PH_W'(WT_PH);
    localparam logic [PH_W-1:0]  PH_CT    = PH_W'(CT_PH);
    localparam logic [JAM_W-1:0] JAM_INIT = JAM_W'(GOJAM_CYC);
    localparam logic [NUM_T-1:0] RING_T01 = NUM_T'(1);

    // Ring bits of the odd-numbered pulses T01, T03, ... (even bit indices)
    function automatic logic [NUM_T-1:0] odd_pulse_mask();
        logic [NUM_T-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_T; i += 2) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [NUM_T-1:0] ODD_MASK = odd_pulse_mask();

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_STEP = 2'd2
    } stop_state_t;

    stop_state_t       state, state_nx;
    logic              idle, idle_nx;
    logic [PH_W-1:0]   ph, ph_nx;
    logic [NUM_T-1:0]  ring, ring_nx;
    logic [JAM_W-1:0]  jam, jam_nx;
    logic [CNT_W-1:0]  mct, mct_nx;
    logic              mstrtp_q;
    logic              step_edge;
    logic              mct_end;
    logic              last_ph;

    // Register all timing state; the ring is kept one-hot so T is a direct gated copy
    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            state    <= S_RUN;
            idle     <= 1'b1;
            ph       <= '0;
            ring     <= RING_T01;
            jam      <= JAM_INIT;
            mct      <= '0;
            mstrtp_q <= 1'b0;
        end else begin
            state    <= state_nx;
            idle     <= idle_nx;
            ph       <= ph_nx;
            ring     <= ring_nx;
            jam      <= jam_nx;
            mct      <= mct_nx;
            mstrtp_q <= MSTRTP;
        end
    end

    // Next state: restart beats everything, then GOJAM countdown, then ring advance and stop/step control
    always_comb begin
        state_nx  = state;
        idle_nx   = idle;
        ph_nx     = ph;
        ring_nx   = ring;
        jam_nx    = jam;
        mct_nx    = mct;
        last_ph   = (ph == PH_LAST);
        mct_end   = !idle && last_ph && ring[NUM_T-1];
        step_edge = MSTRTP && !mstrtp_q;

        if (STRT1 || STRT2) begin
            jam_nx   = JAM_INIT;
            ph_nx    = '0;
            ring_nx  = RING_T01;
            idle_nx  = 1'b1;
            state_nx = S_RUN;
        end else if (jam != '0) begin
            jam_nx = jam - JAM_W'(1);
            if (jam == JAM_W'(1)) idle_nx = 1'b0;
        end else begin
            if (!idle) begin
                if (last_ph) begin
                    ph_nx   = '0;
                    ring_nx = {ring[NUM_T-2:0], ring[NUM_T-1]};
                end else begin
                    ph_nx = ph + PH_W'(1);
                end
                if (mct_end) mct_nx = mct + CNT_W'(1);
            end

            case (state)
                S_RUN: begin
                    // A stop request only takes effect once the current MCT has finished
                    if (mct_end && MSTP) begin
                        state_nx = S_HALT;
                        idle_nx  = 1'b1;
                        ph_nx    = '0;
                        ring_nx  = RING_T01;
                    end
                end
                S_HALT: begin
                    if (!MSTP) begin
                        state_nx = S_RUN;
                        idle_nx  = 1'b0;
                    end else if (step_edge) begin
                        state_nx = S_STEP;
                        idle_nx  = 1'b0;
                    end
                end
                S_STEP: begin
                    if (!MSTP) begin
                        state_nx = S_RUN;
                    end else if (mct_end) begin
                        state_nx = S_HALT;
                        idle_nx  = 1'b1;
                        ph_nx    = '0;
                        ring_nx  = RING_T01;
                    end
                end
                default: state_nx = S_RUN;
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        T       = idle ? '0 : ring;
        T_      = ~T;
        PHS2    = !idle && (ph == PH_W'(1));
        PHS4    = !idle && (ph == PH_W'(3));
        RT      = !idle && (ph == PH_RT);
        WT      = !idle && (ph == PH_WT);
        CT      = !idle && (ph == PH_CT);
        EVNSET  = !idle && (ph == PH_LAST) && |(ring & ODD_MASK);
        ODDSET_ = !(!idle && (ph == PH_LAST) && |(ring & ~ODD_MASK));
        GOJAM   = (jam != '0);
        GOJAM_  = (jam == '0);
        STOP    = (state == S_HALT);
        MCT     = mct;
    end

`ifdef AGC_TPG_MON_EN
    logic [NUM_T-1:0] mt_q;
    logic             idle_q;
    logic             terr_q;
    logic             ring_bad;

    // The delayed copy of T is judged against the idle flag of the same cycle
    always_comb begin
        if (idle_q) ring_bad = (mt_q != '0);
        else        ring_bad = (mt_q == '0) || ((mt_q & (mt_q - NUM_T'(1))) != '0);
    end

    // Monitor copy of T and sticky ring-integrity flag, cleared while GOJAM is up
    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            mt_q   <= '0;
            idle_q <= 1'b1;
            terr_q <= 1'b0;
        end else begin
            mt_q   <= T;
            idle_q <= idle;
            if (GOJAM)         terr_q <= 1'b0;
            else if (ring_bad) terr_q <= 1'b1;
        end
    end

    assign MT   = mt_q;
    assign TERR = terr_q;
`else
    assign MT   = '0;
    assign TERR = 1'b0;
`endif

endmodule

// File: tb/tb_agc_timepulse_gen.sv
// tb/tb_agc_timepulse_gen.sv - directed self-checking bench for agc_timepulse_gen
module tb_agc_timepulse_gen;

    logic        CLOCK = 1'b0;
    logic        rst, strt1, strt2, mstp, mstrtp;
    logic [11:0] t, t_n, mt;
    logic        phs2, phs4, rt, wt, ct, evnset, oddset_n, gojam, gojam_n, stop, terr;
    logic [15:0] mct;

    logic        strt2_b;
    logic        zero_b = 1'b0;
    logic [7:0]  t8, t8_n, mt8;
    logic        phs2_8, phs4_8, rt8, wt8, ct8, evn8, odd8_n, gojam8, gojam8_n, stop8, terr8;
    logic [15:0] mct8;

    int checks = 0;
    int errors = 0;

    always #5 CLOCK = ~CLOCK;

    agc_timepulse_gen dut (
        .CLOCK(CLOCK), .rst(rst), .STRT1(strt1), .STRT2(strt2), .MSTP(mstp), .MSTRTP(mstrtp),
        .T(t), .T_(t_n), .PHS2(phs2), .PHS4(phs4), .RT(rt), .WT(wt), .CT(ct),
        .EVNSET(evnset), .ODDSET_(oddset_n), .GOJAM(gojam), .GOJAM_(gojam_n), .STOP(stop),
        .MCT(mct), .MT(mt), .TERR(terr)
    );

    agc_timepulse_gen #(.NUM_T(8), .PHASES(6)) dut8 (
        .CLOCK(CLOCK), .rst(rst), .STRT1(zero_b), .STRT2(strt2_b), .MSTP(zero_b), .MSTRTP(zero_b),
        .T(t8), .T_(t8_n), .PHS2(phs2_8), .PHS4(phs4_8), .RT(rt8), .WT(wt8), .CT(ct8),
        .EVNSET(evn8), .ODDSET_(odd8_n), .GOJAM(gojam8), .GOJAM_(gojam8_n), .STOP(stop8),
        .MCT(mct8), .MT(mt8), .TERR(terr8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLOCK);
    endtask

    task automatic wait_t(input logic [11:0] v, input string tag);
        int n;
        n = 0;
        while (t !== v && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_reached"}, 32'(t == v), 32'd1);
    endtask

    initial begin
        int cyc, n, nz, n_jam, n_evn, n_odd, n_both, mct0, bad_t, bad_mt;
        logic [11:0] last_t;
        logic [15:0] old;
        logic [7:0]  exp_t, exp_mt;

        rst = 1'b0; strt1 = 1'b0; strt2 = 1'b0; mstp = 1'b0; mstrtp = 1'b0; strt2_b = 1'b0;
        step(); step(); step();

        chk("rst_gojam",   gojam,    1);
        chk("rst_gojam_n", gojam_n,  0);
        chk("rst_t",       t,        0);
        chk("rst_t_n",     t_n,      12'hFFF);
        chk("rst_strobes", {phs2, phs4, rt, wt, ct, evnset}, 0);
        chk("rst_oddset_n", oddset_n, 1);
        chk("rst_stop",    stop,     0);
        chk("rst_mct",     mct,      0);
        chk("rst_mt",      mt,       0);
        chk("rst_terr",    terr,     0);

        // Power-on GOJAM and first MCT, cycle 1 = first cycle after reset release
        rst = 1'b1;
        cyc = 1; n_jam = 0; n_evn = 0; n_odd = 0; n_both = 0;
        while (cyc <= 57) begin
            if (gojam) n_jam++;
            if (cyc >= 9 && cyc <= 56) begin
                if (evnset) n_evn++;
                if (!oddset_n) n_odd++;
                if (evnset && !oddset_n) n_both++;
            end
            case (cyc)
                8:  chk("c8_t_zero", t, 0);
                9:  begin
                        chk("c9_t01", t, 12'h001);
                        chk("c9_rt", rt, 1);
                        chk("c9_gojam_n", gojam_n, 1);
                    end
                10: chk("c10_phs2", phs2, 1);
                11: chk("c11_wt", wt, 1);
                12: chk("c12_ct_phs4_evn", {ct, phs4, evnset}, 3'b111);
                13: chk("c13_t02", t, 12'h002);
                16: chk("c16_oddset_n", oddset_n, 0);
                56: chk("c56_t12_mct", {t, mct}, {12'h800, 16'd0});
                57: chk("c57_wrap_mct", {t, mct}, {12'h001, 16'd1});
                default: ;
            endcase
            step();
            cyc++;
        end
        chk("pwron_jam_len", n_jam, 8);
        chk("evnset_count", n_evn, 6);
        chk("oddset_count", n_odd, 6);
        chk("evn_odd_overlap", n_both, 0);

        // Restart mid-pulse during T05
        wait_t(12'h010, "t05");
        step();
        strt1 = 1'b1;
        step();
        strt1 = 1'b0;
        n = 0; nz = 0;
        while (gojam && n < 20) begin
            if (t != 0) nz++;
            n++;
            step();
        end
        chk("restart_jam_len", n, 8);
        chk("restart_t_zero", nz, 0);
        chk("restart_t01", t, 12'h001);
        chk("restart_mct", mct, 1);

        // Monitor stop raised during T06
        wait_t(12'h020, "t06");
        mct0 = int'(mct);
        mstp = 1'b1;
        n = 0; last_t = '0;
        while (!stop && n < 100) begin
            if (t != 0) last_t = t;
            n++;
            step();
        end
        chk("stop_run_len", n, 28);
        chk("stop_last_t12", last_t, 12'h800);
        chk("stop_t_zero", t, 0);
        chk("stop_mct", mct, 32'(mct0 + 1));
        step(); step(); step();
        chk("halt_hold", {stop, t}, {1'b1, 12'h000});

        // Single step
        mstrtp = 1'b1;
        step();
        chk("step_t01", {stop, t}, {1'b0, 12'h001});
        n = 0;
        while (!stop && n < 100) begin
            if (t != 0) n++;
            step();
        end
        chk("step_len", n, 48);
        chk("step_mct", mct, 32'(mct0 + 2));
        nz = 0;
        for (int i = 0; i < 60; i++) begin
            if (t != 0 || !stop) nz++;
            step();
        end
        chk("step_held_no_restep", nz, 0);
        mstrtp = 1'b0;
        step();
        mstp = 1'b0;
        step();
        chk("resume_t01", {stop, t}, {1'b0, 12'h001});

        // MCT wrap from all ones
        step();
        force dut.mct = 16'hFFFF;
        step();
        release dut.mct;
        wait_t(12'h800, "wrap_t12");
        wait_t(12'h001, "wrap_t01");
        chk("mct_wrap", mct, 0);

        // NUM_T=8, PHASES=6 instance: MCT period and T/MT sequence
        old = mct8; n = 0;
        while (mct8 == old && n < 200) begin step(); n++; end
        old = mct8; n = 0;
        do begin
            step();
            n++;
        end while (mct8 == old && n < 200);
        chk("p8_period", n, 48);
        bad_t = 0; bad_mt = 0;
        for (int k = 0; k < 60; k++) begin
            exp_t = 8'd1 << ((k / 6) % 8);
`ifdef AGC_TPG_MON_EN
            exp_mt = (k == 0) ? 8'h80 : (8'd1 << (((k - 1) / 6) % 8));
`else
            exp_mt = 8'h00;
`endif
            if (t8 !== exp_t) bad_t++;
            if (mt8 !== exp_mt) bad_mt++;
            step();
        end
        chk("p8_t_seq", bad_t, 0);
        chk("p8_mt_seq", bad_mt, 0);
        chk("p8_terr_clean", terr8, 0);

`ifdef AGC_TPG_MON_EN
        force dut8.ring = 8'h03;
        step();
        release dut8.ring;
        step(); step(); step(); step();
        chk("terr_set", terr8, 1);
        for (int i = 0; i < 10; i++) step();
        chk("terr_sticky", terr8, 1);
        strt2_b = 1'b1;
        step();
        strt2_b = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("terr_cleared", {terr8, gojam8, t8}, {1'b0, 1'b0, 8'h01});
        for (int i = 0; i < 20; i++) step();
        chk("terr_stays_clear", terr8, 0);
`else
        chk("terr_off_main", terr, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
